// File: rtl/onchip_mem_dual_arbiter.sv
// Two-master Avalon-MM front end for a single-port on-chip RAM.
// Round-robin grant, one access per cycle, fixed-latency read return.
module onchip_mem_dual_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic req0;
    logic req1;
    logic rd0;
    logic rd1;
    logic grant0;
    logic grant1;
    logic last_grant;
    logic rd_issue;
    logic s0_valid;
    logic s0_owner;
    logic out_valid;
    logic out_owner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // A read asserted together with a write is dropped.
    assign rd0 = m0_read & ~m0_write;
    assign rd1 = m1_read & ~m1_write;

    // Round-robin pick; reset masks both grants.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0 && (!req1 || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = grant0 | grant1;
    assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign mem_clken      = reset_n;

    assign rd_issue = (grant0 & rd0) | (grant1 & rd1);

    // Remember the last winner so contention alternates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // First return stage: tag each granted read with its owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_owner <= 1'b0;
        end else begin
            s0_valid <= rd_issue;
            s0_owner <= grant1;
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_lat2
            logic s1_valid;
            logic s1_owner;

            // Extra stage matching a RAM with registered q.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_valid <= 1'b0;
                    s1_owner <= 1'b0;
                end else begin
                    s1_valid <= s0_valid;
                    s1_owner <= s0_owner;
                end
            end

            assign out_valid = s1_valid;
            assign out_owner = s1_owner;
        end else begin : g_lat1
            assign out_valid = s0_valid;
            assign out_owner = s0_owner;
        end
    endgenerate

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = out_valid & ~out_owner;
    assign m1_readdatavalid = out_valid & out_owner;

endmodule

// File: tb/tb_onchip_mem_dual_arbiter.sv
// Scoreboard bench for onchip_mem_dual_arbiter.
// Two instances: READ_LATENCY 1 and 2, each with a behavioural RAM.
module tb_onchip_mem_dual_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct {
        int          m;
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] t_addr [2][2];
    logic [BW-1:0] t_be   [2][2];
    logic          t_rd   [2][2];
    logic          t_wr   [2][2];
    logic [DW-1:0] t_wd   [2][2];
    logic          t_wait [2][2];
    logic [DW-1:0] t_rdat [2][2];
    logic          t_rv   [2][2];

    logic [AW-1:0] m_addr [2];
    logic [BW-1:0] m_be   [2];
    logic          m_cs   [2];
    logic          m_we   [2];
    logic [DW-1:0] m_wd   [2];
    logic          m_ck   [2];
    logic [DW-1:0] m_rd   [2];

    exp_t sb0[$];
    exp_t sb1[$];

    onchip_mem_dual_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .reset_n(rst_n),
        .m0_address(t_addr[0][0]), .m0_byteenable(t_be[0][0]),
        .m0_read(t_rd[0][0]), .m0_write(t_wr[0][0]),
        .m0_writedata(t_wd[0][0]), .m0_waitrequest(t_wait[0][0]),
        .m0_readdata(t_rdat[0][0]), .m0_readdatavalid(t_rv[0][0]),
        .m1_address(t_addr[0][1]), .m1_byteenable(t_be[0][1]),
        .m1_read(t_rd[0][1]), .m1_write(t_wr[0][1]),
        .m1_writedata(t_wd[0][1]), .m1_waitrequest(t_wait[0][1]),
        .m1_readdata(t_rdat[0][1]), .m1_readdatavalid(t_rv[0][1]),
        .mem_address(m_addr[0]), .mem_byteenable(m_be[0]),
        .mem_chipselect(m_cs[0]), .mem_write(m_we[0]),
        .mem_writedata(m_wd[0]), .mem_clken(m_ck[0]),
        .mem_readdata(m_rd[0])
    );

    onchip_mem_dual_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut1 (
        .clk(clk), .reset_n(rst_n),
        .m0_address(t_addr[1][0]), .m0_byteenable(t_be[1][0]),
        .m0_read(t_rd[1][0]), .m0_write(t_wr[1][0]),
        .m0_writedata(t_wd[1][0]), .m0_waitrequest(t_wait[1][0]),
        .m0_readdata(t_rdat[1][0]), .m0_readdatavalid(t_rv[1][0]),
        .m1_address(t_addr[1][1]), .m1_byteenable(t_be[1][1]),
        .m1_read(t_rd[1][1]), .m1_write(t_wr[1][1]),
        .m1_writedata(t_wd[1][1]), .m1_waitrequest(t_wait[1][1]),
        .m1_readdata(t_rdat[1][1]), .m1_readdatavalid(t_rv[1][1]),
        .mem_address(m_addr[1]), .mem_byteenable(m_be[1]),
        .mem_chipselect(m_cs[1]), .mem_write(m_we[1]),
        .mem_writedata(m_wd[1]), .mem_clken(m_ck[1]),
        .mem_readdata(m_rd[1])
    );

    // Behavioural RAMs: registered address, byte-enabled write.
    logic [DW-1:0] ram0 [0:8191];
    logic [DW-1:0] ram1 [0:8191];
    logic [AW-1:0] ra0 = '0;
    logic [AW-1:0] ra1 = '0;
    logic [DW-1:0] q1  = '0;

    always @(posedge clk) begin
        if (m_ck[0]) begin
            if (m_cs[0] && m_we[0])
                for (int b = 0; b < BW; b++)
                    if (m_be[0][b]) ram0[m_addr[0]][8*b +: 8] <= m_wd[0][8*b +: 8];
            ra0 <= m_addr[0];
        end
        if (m_ck[1]) begin
            if (m_cs[1] && m_we[1])
                for (int b = 0; b < BW; b++)
                    if (m_be[1][b]) ram1[m_addr[1]][8*b +: 8] <= m_wd[1][8*b +: 8];
            ra1 <= m_addr[1];
            q1  <= ram1[ra1];
        end
    end

    assign m_rd[0] = ram0[ra0];
    assign m_rd[1] = q1;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", n, act, req, cyc);
        end
    endfunction

    function automatic void push(int d, exp_t e);
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endfunction

    // Monitor: every readdatavalid pops the scoreboard and is compared.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (t_rv[d][m] === 1'b1) begin
                    exp_t e;
                    bit   have;
                    have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                    if (!have) begin
                        checks++;
                        failures++;
                        $display("FAIL rdv_unexpected dut=%0d m=%0d actual=1 required=0 cyc=%0d",
                                 d, m, cyc);
                    end else begin
                        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk($sformatf("rdv_owner_d%0d", d), m, e.m);
                        chk($sformatf("rdv_data_d%0d", d), t_rdat[d][m], e.d);
                        chk($sformatf("rdv_cycle_d%0d", d), cyc, e.due);
                    end
                end
            end
        end
    end

    // One access: hold until granted, check stall count and slave write.
    task automatic op(input int d, input int m, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_d,
                      input int exp_stall);
        int stall = 0;
        bit got = 0;
        t_addr[d][m] = a;
        t_be[d][m]   = be;
        t_wd[d][m]   = wd;
        t_rd[d][m]   = rd;
        t_wr[d][m]   = wr;
        while (!got && stall < 20) begin
            @(negedge clk);
            if (t_wait[d][m] === 1'b0) begin
                got = 1;
                chk("mem_write", m_we[d], wr);
                chk("mem_cs", m_cs[d], 1'b1);
                if (rd && !wr) push(d, '{m, exp_d, cyc + d + 1});
            end else begin
                stall++;
            end
        end
        chk("granted", got, 1'b1);
        chk($sformatf("stalls_d%0d_m%0d", d, m), stall, exp_stall);
        @(posedge clk);
        #1;
        t_rd[d][m] = 1'b0;
        t_wr[d][m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                t_addr[d][m] = '0;
                t_be[d][m]   = '0;
                t_rd[d][m]   = 1'b0;
                t_wr[d][m]   = 1'b0;
                t_wd[d][m]   = '0;
            end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cs", m_cs[0], 1'b0);
        chk("rst_clken", m_ck[0], 1'b0);
        chk("rst_we", m_we[0], 1'b0);
        chk("rst_rv0", t_rv[0][0], 1'b0);
        chk("rst_rv1", t_rv[0][1], 1'b0);
        chk("rst_wait0", t_wait[0][0], 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("clken_run", m_ck[0], 1'b1);

        // Write then immediate read of the same word.
        op(0, 0, 0, 1, 13'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        op(0, 0, 1, 0, 13'h0010, 4'hF, 32'h0, 32'hDEADBEEF, 0);

        // Byte-lane write at the top address.
        op(0, 0, 0, 1, 13'h1FFF, 4'hF, 32'h11223344, 32'h0, 0);
        op(0, 1, 0, 1, 13'h1FFF, 4'h5, 32'hAABBCCDD, 32'h0, 0);
        op(0, 1, 1, 0, 13'h1FFF, 4'hF, 32'h0, 32'h11BB33DD, 0);

        // Read and write together behave as a write.
        op(0, 0, 1, 1, 13'h0005, 4'hF, 32'h0000CAFE, 32'h0, 0);
        op(0, 0, 1, 0, 13'h0005, 4'hF, 32'h0, 32'h0000CAFE, 0);

        // Preload, then contention straight out of reset.
        op(0, 0, 0, 1, 13'h0000, 4'hF, 32'hA0A0A0A0, 32'h0, 0);
        op(0, 1, 0, 1, 13'h0001, 4'hF, 32'hB1B1B1B1, 32'h0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            for (int i = 0; i < 3; i++)
                op(0, 0, 1, 0, 13'h0000, 4'hF, 32'h0, 32'hA0A0A0A0, (i == 0) ? 0 : 1);
            for (int i = 0; i < 3; i++)
                op(0, 1, 1, 0, 13'h0001, 4'hF, 32'h0, 32'hB1B1B1B1, 1);
        join

        // Reset while an m1 read is granted: it must never return.
        t_addr[0][1] = 13'h0001;
        t_be[0][1]   = 4'hF;
        t_rd[0][1]   = 1'b1;
        @(negedge clk);
        chk("midrd_grant", t_wait[0][1], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrd_wait", t_wait[0][1], 1'b1);
        chk("midrd_cs", m_cs[0], 1'b0);
        chk("midrd_we", m_we[0], 1'b0);
        chk("midrd_clken", m_ck[0], 1'b0);
        @(negedge clk);
        chk("midrd_rv1", t_rv[0][1], 1'b0);
        t_rd[0][1] = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            op(0, 0, 1, 0, 13'h0000, 4'hF, 32'h0, 32'hA0A0A0A0, 0);
            op(0, 1, 1, 0, 13'h0001, 4'hF, 32'h0, 32'hB1B1B1B1, 1);
        join

        // Two-cycle read latency instance.
        op(1, 0, 0, 1, 13'h0002, 4'hF, 32'h22222222, 32'h0, 0);
        op(1, 1, 0, 1, 13'h0003, 4'hF, 32'h33333333, 32'h0, 0);
        fork
            op(1, 0, 1, 0, 13'h0002, 4'hF, 32'h0, 32'h22222222, 0);
            op(1, 1, 1, 0, 13'h0003, 4'hF, 32'h0, 32'h33333333, 1);
        join

        repeat (6) @(negedge clk);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
